dispatch_unit: RTL and testbench

Dispatch stage between rename and the centralized issue queue. Buffers renamed instruction groups in an in-order circular FIFO and writes up to DECODE_NUM instructions per cycle into free issue-queue entries. For each dispatched instruction it supplies the initial source-ready bits from a physical-register busy table and an age tag. It is the producer side of the issue queue's entry-write interface; the issue queue's wake-up broadcast and writeback clear the busy bits.

---
 rtl/dispatch_unit_pkg.sv | 58 +++++
 rtl/dispatch_unit_if.sv | 59 +++++
 rtl/dispatch_unit_busy_table.sv | 52 +++++
 rtl/dispatch_unit.sv | 152 +++++++++++++++
 tb/tb_dispatch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_unit_pkg
//  Function : Shared dispatch/issue-queue widths, payload layout and helpers.
//  Revision : 1.0
// ============================================================================
package dispatch_unit_pkg;

    localparam int DECODE_NUM = 4;
    localparam int ISSUE_NUM  = 4;
    localparam int PRF_WIDTH  = 6;
    localparam int PRF_DEPTH  = 2 ** PRF_WIDTH;
    localparam int AGE_WIDTH  = 5;
    localparam int CIQ_DEPTH  = 16;
    localparam int IQ_CNT_W   = $clog2(CIQ_DEPTH) + 1;

    // Payload is opcode | func3 | func7 | imme, MSB to LSB
    localparam int OPCODE_W   = 7;
    localparam int FUNC3_W    = 3;
    localparam int FUNC7_W    = 1;
    localparam int IMME_W     = 64;
    localparam int PAY_WIDTH  = OPCODE_W + FUNC3_W + FUNC7_W + IMME_W;
    localparam int IMME_LSB   = 0;
    localparam int FUNC7_LSB  = IMME_LSB + IMME_W;
    localparam int FUNC3_LSB  = FUNC7_LSB + FUNC7_W;
    localparam int OPCODE_LSB = FUNC3_LSB + FUNC3_W;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef logic [PRF_WIDTH-1:0] preg_t;
    typedef logic [PAY_WIDTH-1:0] payload_t;
    typedef logic [AGE_WIDTH-1:0] age_t;

    typedef struct packed {
        payload_t payload;
        logic     prs1_v;
        logic     prs2_v;
        logic     prd_v;
        preg_t    prs1;
        preg_t    prs2;
        preg_t    prd;
    } dp_entry_t;

    function automatic logic [$clog2(DECODE_NUM):0] lane_popcount(
        input logic [DECODE_NUM-1:0] v
    );
        lane_popcount = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            lane_popcount = lane_popcount + {{$clog2(DECODE_NUM){1'b0}}, v[i]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_unit_if
//  Function : Rename-group input, issue-queue entry-write and wake-up bus.
//  Revision : 1.0
// ============================================================================
interface dispatch_unit_if;
    import dispatch_unit_pkg::*;

    logic     [DECODE_NUM-1:0] rn_valid;
    payload_t [DECODE_NUM-1:0] rn_payload;
    logic     [DECODE_NUM-1:0] rn_prs1_v;
    logic     [DECODE_NUM-1:0] rn_prs2_v;
    logic     [DECODE_NUM-1:0] rn_prd_v;
    preg_t    [DECODE_NUM-1:0] rn_prs1;
    preg_t    [DECODE_NUM-1:0] rn_prs2;
    preg_t    [DECODE_NUM-1:0] rn_prd;
    logic                      rn_ready;

    logic     [IQ_CNT_W-1:0]   iq_free_cnt;
    logic     [DECODE_NUM-1:0] dp_valid;
    payload_t [DECODE_NUM-1:0] dp_payload;
    logic     [DECODE_NUM-1:0] dp_prs1_v;
    logic     [DECODE_NUM-1:0] dp_prs2_v;
    logic     [DECODE_NUM-1:0] dp_prd_v;
    preg_t    [DECODE_NUM-1:0] dp_prs1;
    preg_t    [DECODE_NUM-1:0] dp_prs2;
    preg_t    [DECODE_NUM-1:0] dp_prd;
    logic     [DECODE_NUM-1:0] dp_prs1_rdy;
    logic     [DECODE_NUM-1:0] dp_prs2_rdy;
    age_t     [DECODE_NUM-1:0] dp_age;

    logic     [ISSUE_NUM-1:0]  wb_valid;
    preg_t    [ISSUE_NUM-1:0]  wb_prd;

    // master: the dispatch stage (producer of issue-queue writes)
    modport master (
        input  rn_valid, rn_payload, rn_prs1_v, rn_prs2_v, rn_prd_v,
        input  rn_prs1, rn_prs2, rn_prd,
        output rn_ready,
        input  iq_free_cnt,
        output dp_valid, dp_payload, dp_prs1_v, dp_prs2_v, dp_prd_v,
        output dp_prs1, dp_prs2, dp_prd, dp_prs1_rdy, dp_prs2_rdy, dp_age,
        input  wb_valid, wb_prd
    );

    // slave: rename stage plus issue queue around the dispatch stage
    modport slave (
        output rn_valid, rn_payload, rn_prs1_v, rn_prs2_v, rn_prd_v,
        output rn_prs1, rn_prs2, rn_prd,
        input  rn_ready,
        output iq_free_cnt,
        input  dp_valid, dp_payload, dp_prs1_v, dp_prs2_v, dp_prd_v,
        input  dp_prs1, dp_prs2, dp_prd, dp_prs1_rdy, dp_prs2_rdy, dp_age,
        output wb_valid, wb_prd
    );

endinterface
`default_nettype wire

// File: rtl/dispatch_unit_busy_table.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_unit_busy_table
//  Function : Physical-register pending bits with same-cycle wake-up bypass.
//  Revision : 1.0
// ============================================================================
module dispatch_unit_busy_table
    import dispatch_unit_pkg::*;
(
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic  [DECODE_NUM-1:0]    i_set_en,
    input  wire preg_t [DECODE_NUM-1:0]    i_set_idx,
    input  wire logic  [ISSUE_NUM-1:0]     i_clr_en,
    input  wire preg_t [ISSUE_NUM-1:0]     i_clr_idx,
    input  wire preg_t [2*DECODE_NUM-1:0]  i_rd_idx,
    output logic       [2*DECODE_NUM-1:0]  o_rd_busy
);

    logic [PRF_DEPTH-1:0] r_busy;
    logic [PRF_DEPTH-1:0] w_busy_nxt;

    // Sets are applied after clears so a set wins on a shared index
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (i_clr_en[i]) w_busy_nxt[i_clr_idx[i]] = 1'b0;
        end
        for (int i = 0; i < DECODE_NUM; i++) begin
            if (i_set_en[i]) w_busy_nxt[i_set_idx[i]] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    for (genvar r = 0; r < 2*DECODE_NUM; r++) begin : g_rd
        logic w_wb_hit;
        always_comb begin
            w_wb_hit = 1'b0;
            for (int i = 0; i < ISSUE_NUM; i++) begin
                if (i_clr_en[i] && (i_clr_idx[i] == i_rd_idx[r])) w_wb_hit = 1'b1;
            end
        end
        assign o_rd_busy[r] = r_busy[i_rd_idx[r]] & ~w_wb_hit;
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_unit
//  Function : In-order rename buffer feeding up to DECODE_NUM issue-queue writes.
//  Revision : 1.0
// ============================================================================
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int BUF_DEPTH = 8
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       flush,
    dispatch_unit_if.master bus
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef logic [c_PTR_W-1:0] ptr_t;
    typedef logic [c_CNT_W-1:0] cnt_t;

    dp_entry_t r_buf [BUF_DEPTH];
    ptr_t      r_head;
    ptr_t      r_tail;
    cnt_t      r_count;
    age_t      r_age_ctr;

    logic                      w_accept;
    cnt_t                      w_acc_cnt;
    cnt_t                      w_n;
    dp_entry_t                 w_ent [DECODE_NUM];
    logic [DECODE_NUM-1:0]     w_dp_valid;
    logic [DECODE_NUM-1:0]     w_dep1;
    logic [DECODE_NUM-1:0]     w_dep2;
    preg_t [2*DECODE_NUM-1:0]  w_rd_idx;
    logic  [2*DECODE_NUM-1:0]  w_rd_busy;
    logic  [DECODE_NUM-1:0]    w_set_en;
    preg_t [DECODE_NUM-1:0]    w_set_idx;

    assign bus.rn_ready = (cnt_t'(BUF_DEPTH) - r_count) >= cnt_t'(DECODE_NUM);
    assign w_accept     = bus.rn_ready & (|bus.rn_valid) & ~flush;
    assign w_acc_cnt    = w_accept ? cnt_t'(lane_popcount(bus.rn_valid)) : '0;

    // n = min(count, iq_free_cnt, DECODE_NUM), suppressed during flush
    always_comb begin
        w_n = r_count;
        if (32'(bus.iq_free_cnt) < 32'(w_n)) w_n = cnt_t'(bus.iq_free_cnt);
        if (32'(w_n) > DECODE_NUM)           w_n = cnt_t'(DECODE_NUM);
        if (flush)                           w_n = '0;
    end

    always_comb begin
        for (int k = 0; k < DECODE_NUM; k++) begin
            w_ent[k]          = r_buf[r_head + ptr_t'(k)];
            w_dp_valid[k]     = cnt_t'(k) < w_n;
            w_rd_idx[2*k]     = w_ent[k].prs1;
            w_rd_idx[2*k + 1] = w_ent[k].prs2;
            w_set_en[k]       = w_dp_valid[k] & w_ent[k].prd_v;
            w_set_idx[k]      = w_ent[k].prd;
        end
    end

    // Older lanes in the same dispatch group are not yet in the busy table
    always_comb begin
        w_dep1 = '0;
        w_dep2 = '0;
        for (int k = 1; k < DECODE_NUM; k++) begin
            for (int j = 0; j < k; j++) begin
                if (w_dp_valid[j] && w_ent[j].prd_v && (w_ent[j].prd == w_ent[k].prs1)) w_dep1[k] = 1'b1;
                if (w_dp_valid[j] && w_ent[j].prd_v && (w_ent[j].prd == w_ent[k].prs2)) w_dep2[k] = 1'b1;
            end
        end
    end

    always_comb begin
        bus.dp_valid    = w_dp_valid;
        bus.dp_payload  = '0;
        bus.dp_prs1_v   = '0;
        bus.dp_prs2_v   = '0;
        bus.dp_prd_v    = '0;
        bus.dp_prs1     = '0;
        bus.dp_prs2     = '0;
        bus.dp_prd      = '0;
        bus.dp_prs1_rdy = '0;
        bus.dp_prs2_rdy = '0;
        bus.dp_age      = '0;
        for (int k = 0; k < DECODE_NUM; k++) begin
            if (w_dp_valid[k]) begin
                bus.dp_payload[k]  = w_ent[k].payload;
                bus.dp_prs1_v[k]   = w_ent[k].prs1_v;
                bus.dp_prs2_v[k]   = w_ent[k].prs2_v;
                bus.dp_prd_v[k]    = w_ent[k].prd_v;
                bus.dp_prs1[k]     = w_ent[k].prs1;
                bus.dp_prs2[k]     = w_ent[k].prs2;
                bus.dp_prd[k]      = w_ent[k].prd;
                bus.dp_prs1_rdy[k] = ~w_ent[k].prs1_v | (~w_rd_busy[2*k]     & ~w_dep1[k]);
                bus.dp_prs2_rdy[k] = ~w_ent[k].prs2_v | (~w_rd_busy[2*k + 1] & ~w_dep2[k]);
                bus.dp_age[k]      = r_age_ctr + age_t'(k);
            end
        end
    end

    dispatch_unit_busy_table u_busy_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (w_set_en),
        .i_set_idx (w_set_idx),
        .i_clr_en  (bus.wb_valid),
        .i_clr_idx (bus.wb_prd),
        .i_rd_idx  (w_rd_idx),
        .o_rd_busy (w_rd_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_age_ctr <= '0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            r_head    <= r_head + ptr_t'(w_n);
            r_tail    <= r_tail + ptr_t'(w_acc_cnt);
            r_count   <= r_count + w_acc_cnt - w_n;
            r_age_ctr <= r_age_ctr + age_t'(w_n);
        end
    end

    // Entry storage needs no reset: every read is qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < DECODE_NUM; k++) begin
                if (bus.rn_valid[k]) begin
                    r_buf[r_tail + ptr_t'(k)] <= '{payload: bus.rn_payload[k],
                                                   prs1_v:  bus.rn_prs1_v[k],
                                                   prs2_v:  bus.rn_prs2_v[k],
                                                   prd_v:   bus.rn_prd_v[k],
                                                   prs1:    bus.rn_prs1[k],
                                                   prs2:    bus.rn_prs2[k],
                                                   prd:     bus.rn_prd[k]};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_unit
//  Function : Directed vector bench for dispatch_unit.
//  Revision : 1.0
// ============================================================================
module tb_dispatch_unit;
    import dispatch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    dispatch_unit_if bus();

    dispatch_unit #(.BUF_DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int rn_cnt;
        int rn_base;
        int iq;
        int exp_rdy;
        int exp_n;
        int exp_age0;
        int exp_pay0;
    } vec_t;

    vec_t vecs [10];

    // reference model state for the long run
    int q[$];
    int cnt_m;
    int age_m;
    int seq;
    int dispatched;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rn();
        bus.rn_valid   = '0;
        bus.rn_payload = '0;
        bus.rn_prs1_v  = '0;
        bus.rn_prs2_v  = '0;
        bus.rn_prd_v   = '0;
        bus.rn_prs1    = '0;
        bus.rn_prs2    = '0;
        bus.rn_prd     = '0;
    endtask

    task automatic idle_inputs();
        clear_rn();
        bus.iq_free_cnt = '0;
        bus.wb_valid    = '0;
        bus.wb_prd      = '0;
        flush           = 1'b0;
    endtask

    task automatic set_lane(input int k, input int pay, input bit d_v, input int d,
                            input bit s1_v, input int s1, input bit s2_v, input int s2);
        bus.rn_valid[k]   = 1'b1;
        bus.rn_payload[k] = payload_t'(pay);
        bus.rn_prd_v[k]   = d_v;
        bus.rn_prd[k]     = preg_t'(d);
        bus.rn_prs1_v[k]  = s1_v;
        bus.rn_prs1[k]    = preg_t'(s1);
        bus.rn_prs2_v[k]  = s2_v;
        bus.rn_prs2[k]    = preg_t'(s2);
    endtask

    task automatic group(input int cnt, input int base);
        clear_rn();
        for (int k = 0; k < cnt; k++) set_lane(k, base + k, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lanes(input string tag, input int n, input int age0, input int pay0);
        chk({tag, "_dp_valid"}, 80'(bus.dp_valid), 80'((1 << n) - 1));
        for (int k = 0; k < DECODE_NUM; k++) begin
            if (k < n) begin
                chk($sformatf("%s_pay%0d", tag, k), 80'(bus.dp_payload[k]), 80'(pay0 + k));
                chk($sformatf("%s_age%0d", tag, k), 80'(bus.dp_age[k]), 80'((age0 + k) % 32));
            end else begin
                chk($sformatf("%s_pay%0d_idle", tag, k), 80'(bus.dp_payload[k]), 80'(0));
                chk($sformatf("%s_age%0d_idle", tag, k), 80'(bus.dp_age[k]), 80'(0));
            end
        end
    endtask

    task automatic model_cycle(input string tag, input int rc, input int iq);
        int n;
        bit er;
        er = (8 - cnt_m) >= 4;
        n  = cnt_m;
        if (iq < n) n = iq;
        if (n > 4)  n = 4;
        idle_inputs();
        group(rc, seq);
        bus.iq_free_cnt = IQ_CNT_W'(iq);
        #1;
        chk({tag, "_rn_ready"}, 80'(bus.rn_ready), 80'(er));
        chk_lanes(tag, n, age_m, (n > 0) ? q[0] : 0);
        tick();
        for (int k = 0; k < n; k++) void'(q.pop_front());
        dispatched += n;
        cnt_m      -= n;
        age_m       = (age_m + n) % 32;
        if (er && rc > 0) begin
            for (int k = 0; k < rc; k++) q.push_back(seq + k);
            cnt_m += rc;
            seq   += rc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // rn_cnt rn_base iq exp_rdy exp_n exp_age0 exp_pay0
        vecs[0] = '{4, 109, 16, 1, 0,  0,   0};
        vecs[1] = '{0,   0,  2, 1, 2,  9, 109};
        vecs[2] = '{0,   0, 16, 1, 2, 11, 111};
        vecs[3] = '{4, 113,  0, 1, 0,  0,   0};
        vecs[4] = '{4, 117,  0, 1, 0,  0,   0};
        vecs[5] = '{4, 121,  0, 0, 0,  0,   0};
        vecs[6] = '{4, 121,  4, 0, 4, 13, 113};
        vecs[7] = '{4, 121,  0, 1, 0,  0,   0};
        vecs[8] = '{0,   0,  4, 0, 4, 17, 117};
        vecs[9] = '{0,   0,  4, 1, 4, 21, 121};

        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("reset_rn_ready", 80'(bus.rn_ready), 80'(1));
        chk("reset_dp_valid", 80'(bus.dp_valid), 80'(0));
        chk("reset_dp_age", 80'(bus.dp_age), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // first group: destinations 10..13
        idle_inputs();
        for (int k = 0; k < 4; k++) set_lane(k, 100 + k, 1'b1, 10 + k, 1'b0, 0, 1'b0, 0);
        bus.iq_free_cnt = 5'd16;
        #1;
        chk("c0_rn_ready", 80'(bus.rn_ready), 80'(1));
        chk("c0_no_bypass", 80'(bus.dp_valid), 80'(0));
        tick();

        idle_inputs();
        bus.iq_free_cnt = 5'd16;
        #1;
        chk_lanes("c1", 4, 0, 100);
        for (int k = 0; k < 4; k++) chk($sformatf("c1_prd%0d", k), 80'(bus.dp_prd[k]), 80'(10 + k));
        chk("c1_prd_v", 80'(bus.dp_prd_v), 80'(4'b1111));
        tick();

        // consumer of 10 (busy) and 11 (woken this cycle)
        idle_inputs();
        set_lane(0, 104, 1'b0, 0, 1'b1, 10, 1'b1, 11);
        bus.iq_free_cnt = 5'd16;
        #1;
        chk("c2_dp_valid", 80'(bus.dp_valid), 80'(0));
        tick();

        idle_inputs();
        bus.iq_free_cnt = 5'd16;
        bus.wb_valid[0] = 1'b1;
        bus.wb_prd[0]   = 6'd11;
        #1;
        chk_lanes("c3", 1, 4, 104);
        chk("c3_rdy1_busy", 80'(bus.dp_prs1_rdy[0]), 80'(0));
        chk("c3_rdy2_wb_bypass", 80'(bus.dp_prs2_rdy[0]), 80'(1));
        tick();

        // intra-group producer plus wb bypass on another port
        idle_inputs();
        set_lane(0, 105, 1'b1, 20, 1'b0, 0,  1'b0, 0);
        set_lane(1, 106, 1'b0, 0,  1'b1, 20, 1'b1, 11);
        set_lane(2, 107, 1'b0, 0,  1'b1, 12, 1'b0, 0);
        set_lane(3, 108, 1'b0, 0,  1'b1, 10, 1'b1, 13);
        bus.iq_free_cnt = 5'd16;
        #1;
        chk("c4_dp_valid", 80'(bus.dp_valid), 80'(0));
        tick();

        idle_inputs();
        bus.iq_free_cnt = 5'd16;
        bus.wb_valid[1] = 1'b1;
        bus.wb_prd[1]   = 6'd10;
        #1;
        chk_lanes("c5", 4, 5, 105);
        chk("c5_prs1_rdy", 80'(bus.dp_prs1_rdy), 80'(4'b1001));
        chk("c5_prs2_rdy", 80'(bus.dp_prs2_rdy), 80'(4'b0111));
        tick();

        // partial dispatch, fill to full, backpressure and drain
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            group(vecs[i].rn_cnt, vecs[i].rn_base);
            bus.iq_free_cnt = IQ_CNT_W'(vecs[i].iq);
            #1;
            chk($sformatf("v%0d_rn_ready", i), 80'(bus.rn_ready), 80'(vecs[i].exp_rdy));
            chk_lanes($sformatf("v%0d", i), vecs[i].exp_n, vecs[i].exp_age0, vecs[i].exp_pay0);
            tick();
        end

        // long run against the scoreboard: pointer and age wrap
        cnt_m      = 0;
        age_m      = 25;
        seq        = 200;
        dispatched = 0;
        for (int cyc = 0; cyc < 200 && dispatched < 40; cyc++) begin
            model_cycle($sformatf("w%0d", cyc), (cyc % 4) + 1, (cyc * 5) % 7);
        end
        chk("wrap_dispatch_budget", 80'(dispatched >= 40), 80'(1));
        for (int i = 0; i < 10 && cnt_m > 0; i++) model_cycle($sformatf("d%0d", i), 0, 4);
        chk("drain_budget", 80'(cnt_m), 80'(0));

        // flush with six buffered entries
        idle_inputs();
        for (int k = 0; k < 4; k++) set_lane(k, 300 + k, 1'b1, 30 + k, 1'b0, 0, 1'b0, 0);
        #1;
        tick();
        idle_inputs();
        set_lane(0, 304, 1'b1, 34, 1'b0, 0, 1'b0, 0);
        set_lane(1, 305, 1'b1, 35, 1'b0, 0, 1'b0, 0);
        #1;
        chk("f1_rn_ready", 80'(bus.rn_ready), 80'(1));
        tick();
        idle_inputs();
        group(4, 306);
        bus.iq_free_cnt = 5'd16;
        flush = 1'b1;
        #1;
        chk("f2_flush_dp_valid", 80'(bus.dp_valid), 80'(0));
        chk("f2_full_rn_ready", 80'(bus.rn_ready), 80'(0));
        tick();
        idle_inputs();
        group(4, 310);
        bus.iq_free_cnt = 5'd16;
        flush = 1'b1;
        #1;
        chk("f3_rn_ready", 80'(bus.rn_ready), 80'(1));
        chk("f3_dp_valid", 80'(bus.dp_valid), 80'(0));
        tick();
        idle_inputs();
        set_lane(0, 320, 1'b0, 0, 1'b1, 30, 1'b1, 12);
        bus.iq_free_cnt = 5'd16;
        #1;
        chk("f4_nothing_enqueued", 80'(bus.dp_valid), 80'(0));
        tick();
        idle_inputs();
        bus.iq_free_cnt = 5'd16;
        #1;
        chk_lanes("f5", 1, age_m, 320);
        chk("f5_rdy1_not_set", 80'(bus.dp_prs1_rdy[0]), 80'(1));
        chk("f5_rdy2_still_busy", 80'(bus.dp_prs2_rdy[0]), 80'(0));
        tick();
        age_m = (age_m + 1) % 32;

        // asynchronous reset mid-stream
        idle_inputs();
        group(4, 400);
        #1;
        tick();
        idle_inputs();
        bus.iq_free_cnt = 5'd16;
        #1;
        chk_lanes("r1", 4, age_m, 400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r1_async_rn_ready", 80'(bus.rn_ready), 80'(1));
        chk("r1_async_dp_valid", 80'(bus.dp_valid), 80'(0));
        chk("r1_async_dp_age", 80'(bus.dp_age), 80'(0));
        chk("r1_async_dp_payload", 80'(bus.dp_payload), 80'(0));
        #2;
        rst_n = 1'b1;
        tick();
        idle_inputs();
        set_lane(0, 410, 1'b0, 0, 1'b1, 12, 1'b0, 0);
        bus.iq_free_cnt = 5'd16;
        #1;
        chk("r2_empty", 80'(bus.dp_valid), 80'(0));
        tick();
        idle_inputs();
        bus.iq_free_cnt = 5'd16;
        #1;
        chk_lanes("r3", 1, 0, 410);
        chk("r3_busy_cleared", 80'(bus.dp_prs1_rdy[0]), 80'(1));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
